// File: rtl/term_writer_pkg.sv
// Shared definitions for the character-terminal writer: geometry, FSM states
// and the control / escape byte codes it recognises.
package term_writer_pkg;

    localparam int ROWS   = 16;
    localparam int COLS   = 64;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 6;
    localparam int ADDR_W = 10;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_ESC = 8'h1B;

    localparam logic [7:0] ESC_UP        = 8'h41;  // 'A'
    localparam logic [7:0] ESC_DOWN      = 8'h42;  // 'B'
    localparam logic [7:0] ESC_RIGHT     = 8'h43;  // 'C'
    localparam logic [7:0] ESC_LEFT      = 8'h44;  // 'D'
    localparam logic [7:0] ESC_HOME      = 8'h48;  // 'H'
    localparam logic [7:0] ESC_CLR_SCR   = 8'h4A;  // 'J'
    localparam logic [7:0] ESC_CLR_LINE  = 8'h4B;  // 'K'

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ESC   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/term_writer_if.sv
// Host byte stream plus character-buffer write port of the terminal writer.
interface term_writer_if;

    logic [7:0]                        data_in;
    logic                              data_valid;
    logic                              data_ready;
    logic [term_writer_pkg::ADDR_W-1:0] buffer_waddr;
    logic [7:0]                        buffer_din;
    logic                              buffer_wen;

    modport master (
        output data_in, data_valid,
        input  data_ready, buffer_waddr, buffer_din, buffer_wen
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, buffer_waddr, buffer_din, buffer_wen
    );

endinterface

// File: rtl/term_writer_clear_sequencer.sv
// Walks an inclusive address range one cell per cycle. addr_o/wen_o are valid
// in the start cycle itself so the owner can register them with no bubble.
module clear_sequencer
    import term_writer_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wen_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] end_q;
    logic              active_q;
    logic              done_q;
    logic              last;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        wen_o  = start_i | active_q;
        addr_o = start_i ? start_addr_i : addr_q;
        last   = wen_o && (addr_o == (start_i ? end_addr_i : end_q));
    end

    // NOTE: synchronous active-low reset; state updated only with <=.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            addr_q   <= '0;
            end_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last;
            if (start_i) begin
                end_q <= end_addr_i;
            end
            if (wen_o) begin
                active_q <= !last;
                addr_q   <= addr_o + ADDR_W'(1);
            end
        end
    end

    // High in the cycle the owner presents the final registered write.
    assign done_o = done_q;

endmodule

// File: rtl/term_writer.sv
// Byte-stream terminal writer: prints characters into a 16x64 cell buffer,
// tracks the cursor, and handles CR/LF/BS plus a one-byte ESC command set.
module term_writer
    import term_writer_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    term_writer_if.slave     bus,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             busy
);

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              pend_q;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        din_q, din_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic              accept;
    logic              clr_start;
    logic [ADDR_W-1:0] clr_first, clr_last;
    logic [ADDR_W-1:0] seq_addr;
    logic              seq_wen, seq_done;

    assign accept = bus.data_valid && ready_q;

    clear_sequencer u_clear_sequencer (
        .clk          (clk),
        .clr_n        (clr_n),
        .start_i      (clr_start),
        .start_addr_i (clr_first),
        .end_addr_i   (clr_last),
        .addr_o       (seq_addr),
        .wen_o        (seq_wen),
        .done_o       (seq_done)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pend_q  <= 1'b1;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pend_q  <= 1'b0;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        if (pend_q) begin
            state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (accept) begin
                    if (is_printable(bus.data_in)) begin
                        col_d = col_q + COL_W'(1);
                        if (col_q == {COL_W{1'b1}}) row_d = row_q + ROW_W'(1);
                    end else begin
                        case (bus.data_in)
                            CH_CR:   col_d = '0;
                            CH_LF:   row_d = row_q + ROW_W'(1);
                            CH_BS:   if (col_q != '0) col_d = col_q - COL_W'(1);
                            CH_ESC:  state_d = ST_ESC;
                            default: ;
                        endcase
                    end
                end
                ST_ESC: if (accept) begin
                    state_d = ST_IDLE;
                    case (bus.data_in)
                        ESC_HOME:     begin row_d = '0; col_d = '0; end
                        ESC_UP:       if (row_q != '0) row_d = row_q - ROW_W'(1);
                        ESC_DOWN:     if (row_q != {ROW_W{1'b1}}) row_d = row_q + ROW_W'(1);
                        ESC_RIGHT:    if (col_q != {COL_W{1'b1}}) col_d = col_q + COL_W'(1);
                        ESC_LEFT:     if (col_q != '0) col_d = col_q - COL_W'(1);
                        ESC_CLR_SCR,
                        ESC_CLR_LINE: state_d = ST_CLEAR;
                        default:      ;
                    endcase
                end
                ST_CLEAR: if (seq_done) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        clr_start = 1'b0;
        clr_first = {row_q, col_q};
        clr_last  = '1;
        if (pend_q) begin
            clr_start = CLEAR_ON_RESET;
            clr_first = '0;
        end else if (state_q == ST_ESC && accept) begin
            if (bus.data_in == ESC_CLR_SCR) begin
                clr_start = 1'b1;
            end else if (bus.data_in == ESC_CLR_LINE) begin
                clr_start = 1'b1;
                clr_last  = {row_q, {COL_W{1'b1}}};
            end
        end

        // Address and data hold their last value whenever no write is issued.
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        din_d   = din_q;
        if (seq_wen) begin
            wen_d   = 1'b1;
            waddr_d = seq_addr;
            din_d   = BLANK_CHAR;
        end else if (state_q == ST_IDLE && accept && is_printable(bus.data_in)) begin
            wen_d   = 1'b1;
            waddr_d = {row_q, col_q};
            din_d   = bus.data_in;
        end

        busy_d  = (state_d == ST_CLEAR);
        ready_d = (state_d != ST_CLEAR);
    end

    assign bus.data_ready   = ready_q;
    assign bus.buffer_wen   = wen_q;
    assign bus.buffer_waddr = waddr_q;
    assign bus.buffer_din   = din_q;
    assign cursor_row       = row_q;
    assign cursor_col       = col_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_term_writer.sv
// Self-checking bench for term_writer: directed scenarios plus a random byte
// stream checked against a cursor/write-list model of the terminal rules.
module tb_term_writer;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    int checks = 0;
    int errors = 0;

    term_writer_if tbif ();

    always #5 clk = ~clk;

    term_writer #(
        .BLANK_CHAR     (8'h20),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .bus        (tbif.slave),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    // Reference model: cursor as plain integers, expected writes as a list.
    int          m_row = 0;
    int          m_col = 0;
    bit          m_esc = 1'b0;
    bit          mon_en = 1'b0;
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];

    always @(negedge clk) begin
        if (mon_en && tbif.buffer_wen === 1'b1)
            obs_q.push_back({tbif.buffer_waddr, tbif.buffer_din});
    end

    function automatic void model_clear(int first, int last);
        for (int a = first; a <= last; a++) exp_q.push_back({10'(a), 8'h20});
    endfunction

    function automatic void model_reset();
        m_row = 0; m_col = 0; m_esc = 1'b0;
        exp_q.delete(); obs_q.delete();
    endfunction

    function automatic void model_byte(logic [7:0] b);
        int pos = m_row * 64 + m_col;
        if (m_esc) begin
            m_esc = 1'b0;
            case (b)
                8'h48: begin m_row = 0; m_col = 0; end
                8'h41: if (m_row > 0)  m_row--;
                8'h42: if (m_row < 15) m_row++;
                8'h43: if (m_col < 63) m_col++;
                8'h44: if (m_col > 0)  m_col--;
                8'h4A: model_clear(pos, 1023);
                8'h4B: model_clear(pos, m_row * 64 + 63);
                default: ;
            endcase
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({10'(pos), b});
            m_col++;
            if (m_col == 64) begin m_col = 0; m_row = (m_row + 1) % 16; end
        end else begin
            case (b)
                8'h0D: m_col = 0;
                8'h0A: m_row = (m_row + 1) % 16;
                8'h08: if (m_col > 0) m_col--;
                8'h1B: m_esc = 1'b1;
                default: ;
            endcase
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        tbif.data_in    = b;
        tbif.data_valid = 1'b1;
        while (tbif.data_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL send_byte: byte %h never accepted, data_ready=%b required 1", b, tbif.data_ready);
        end else begin
            @(posedge clk);
            model_byte(b);
        end
        #1 tbif.data_valid = 1'b0;
    endtask

    task automatic send_esc(input logic [7:0] cmd, input int times);
        for (int i = 0; i < times; i++) begin
            send_byte(8'h1B);
            send_byte(cmd);
        end
    endtask

    // Drains the scoreboard once the block is idle again.
    task automatic compare_writes(input string name);
        int n = 0;
        int shown = 0;
        while (!(tbif.data_ready === 1'b1 && busy === 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                if (shown < 5) begin
                    $display("FAIL %s write %0d: got addr %h data %h required addr %h data %h",
                             name, i, obs_q[i][17:8], obs_q[i][7:0], exp_q[i][17:8], exp_q[i][7:0]);
                    shown++;
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Called at a negedge just after clr_n is released.
    task automatic test_power_on_clear(input string name);
        int bad = 0;
        mon_en = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            checks++;
            if (!(tbif.buffer_wen === 1'b1 && tbif.buffer_waddr === 10'(i) &&
                  tbif.buffer_din === 8'h20 && busy === 1'b1 && tbif.data_ready === 1'b0)) begin
                errors++;
                if (bad < 5)
                    $display("FAIL %s cycle %0d: wen %b addr %h din %h busy %b ready %b required 1 %h 20 1 0",
                             name, i, tbif.buffer_wen, tbif.buffer_waddr, tbif.buffer_din, busy, tbif.data_ready, 10'(i));
                bad++;
            end
        end
        @(negedge clk);
        checks++;
        if (tbif.buffer_wen !== 1'b0 || busy !== 1'b0 || tbif.data_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end: wen %b busy %b ready %b required 0 0 1", name, tbif.buffer_wen, busy, tbif.data_ready);
        end
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic test_reset_values(input string name);
        checks++;
        if (tbif.buffer_wen !== 1'b0 || tbif.buffer_waddr !== 10'h000 || tbif.buffer_din !== 8'h00 ||
            tbif.data_ready !== 1'b0 || busy !== 1'b0 || cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL %s: wen %b addr %h din %h ready %b busy %b row %0d col %0d required all zero",
                     name, tbif.buffer_wen, tbif.buffer_waddr, tbif.buffer_din, tbif.data_ready, busy, cursor_row, cursor_col);
        end
    endtask

    task automatic test_reset();
        tbif.data_valid = 1'b0;
        tbif.data_in    = 8'h00;
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset_values("reset_state");
        clr_n = 1'b1;
        test_power_on_clear("power_on_clear");
    endtask

    task automatic test_wrap_print();
        send_esc(8'h48, 1);
        send_esc(8'h43, 62);
        send_byte(8'h41);
        send_byte(8'h42);
        compare_writes("wrap_print");
        checks++;
        if (cursor_row !== 4'd1 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL wrap_print cursor: got %0d/%0d required 1/0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_corner();
        send_esc(8'h48, 1);
        send_esc(8'h42, 15);
        send_esc(8'h43, 63);
        send_byte(8'(32 + $urandom_range(0, 94)));
        checks++;
        if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL corner_wrap cursor: got %0d/%0d required 0/0", cursor_row, cursor_col);
        end
        send_byte(8'h0A);
        send_byte(8'h0A);
        compare_writes("corner_wrap");
        checks++;
        if (cursor_row !== 4'd2 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL linefeed cursor: got %0d/%0d required 2/0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_clear_line();
        int low = 0;
        int n = 0;
        send_esc(8'h48, 1);
        send_esc(8'h42, 3);
        send_esc(8'h43, 10);
        compare_writes("clear_line_setup");
        send_byte(8'h1B);
        send_byte(8'h4B);
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (tbif.data_ready === 1'b1) break;
            low++;
        end
        checks++;
        if (low != 54) begin
            errors++;
            $display("FAIL clear_line ready_low: got %0d cycles required 54", low);
        end
        compare_writes("clear_line");
        checks++;
        if (cursor_row !== 4'd3 || cursor_col !== 6'd10) begin
            errors++;
            $display("FAIL clear_line cursor: got %0d/%0d required 3/10", cursor_row, cursor_col);
        end
    endtask

    task automatic test_controls();
        send_esc(8'h48, 1);
        send_byte(8'h08);
        send_esc(8'h41, 1);
        checks++;
        if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL saturate cursor: got %0d/%0d required 0/0", cursor_row, cursor_col);
        end
        send_esc(8'h5A, 1);
        send_byte(8'h78);
        checks++;
        if (exp_q.size() != 1) begin
            errors++;
            $display("FAIL esc_ignore model writes: got %0d required 1", exp_q.size());
        end
        compare_writes("esc_ignore");
    endtask

    task automatic test_random();
        logic [7:0] cmds[9];
        logic [7:0] b;
        cmds = '{8'h48, 8'h41, 8'h42, 8'h43, 8'h44, 8'h4B, 8'h5A, 8'h71, 8'h4A};
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 55)      b = 8'(32 + $urandom_range(0, 94));
            else if (r < 62) b = 8'h0D;
            else if (r < 68) b = 8'h0A;
            else if (r < 74) b = 8'h08;
            else if (r < 78) b = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'($urandom_range(0, 7));
            else begin
                send_byte(8'h1B);
                b = cmds[$urandom_range(0, 7)];
                if ($urandom_range(0, 39) == 0) b = cmds[8];
            end
            send_byte(b);
            checks++;
            if (cursor_row !== 4'(m_row) || cursor_col !== 6'(m_col)) begin
                errors++;
                $display("FAIL random cursor byte %0d (%h): got %0d/%0d required %0d/%0d",
                         i, b, cursor_row, cursor_col, m_row, m_col);
            end
        end
        compare_writes("random");
    endtask

    task automatic test_reset_midclear();
        int n = 0;
        int wr = 0;
        send_esc(8'h48, 1);
        compare_writes("midclear_setup");
        mon_en = 1'b0;
        send_byte(8'h1B);
        send_byte(8'h4A);
        while (wr < 500 && n < 2000) begin
            @(negedge clk);
            n++;
            if (tbif.buffer_wen === 1'b1) wr++;
        end
        checks++;
        if (wr != 500) begin
            errors++;
            $display("FAIL midclear writes seen: got %0d required 500", wr);
        end
        clr_n = 1'b0;
        @(negedge clk);
        test_reset_values("midclear_reset_state");
        clr_n = 1'b1;
        test_power_on_clear("midclear_restart");
    endtask

    task automatic test_reset_in_esc();
        send_byte(8'h1B);
        mon_en = 1'b0;
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        test_reset_values("esc_reset_state");
        clr_n = 1'b1;
        test_power_on_clear("esc_reset_restart");
        send_byte(8'h48);
        compare_writes("esc_reset_abort");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrap_print();
        test_corner();
        test_clear_line();
        test_controls();
        test_random();
        test_reset_midclear();
        test_reset_in_esc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
